// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I major opcodes seen by the main decoder
  localparam logic [6:0] OPCODE_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPCODE_STORE  = 7'b010_0011;
  localparam logic [6:0] OPCODE_OP     = 7'b011_0011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPCODE_JAL    = 7'b110_1111;
  localparam logic [6:0] OPCODE_JALR   = 7'b110_0111;
  localparam logic [6:0] OPCODE_LUI    = 7'b011_0111;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FsReq,
    FsWait,
    FsDrop
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  // Fetch unit side
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  // Memory side
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush beats push.
module instr_fetch_unit_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  fetch_entry_t                 data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while count is zero, so no reset
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches from imem with one request in flight, buffers
// instructions for decode and redirects on taken branch/JAL/JALR.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = XLEN,
  parameter int unsigned          DATA_WIDTH = XLEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  instr_fetch_unit_if.master    imem,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  input  logic                  branch_i,
  input  logic                  jump_i,
  input  logic                  jalr_i,
  input  logic                  zero_i,
  input  logic [ADDR_WIDTH-1:0] pc_target_i,
  input  logic [ADDR_WIDTH-1:0] alu_result_i,
  output logic                  misalign_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  fetch_en_q;
  logic                  misalign_q;

  logic                  req, fire, taken, fifo_push;
  logic [ADDR_WIDTH-1:0] target;
  fetch_entry_t          fifo_head;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;

  assign fire   = instr_valid_o & instr_ready_i;
  assign taken  = fire & (jump_i | jalr_i | (branch_i & zero_i));
  assign target = jalr_i ? {alu_result_i[ADDR_WIDTH-1:1], 1'b0} : pc_target_i;

  // Request only when a slot is guaranteed for the response
  assign req       = fetch_en_q && (state_q == FsReq) && (fifo_count < CntW'(FIFO_DEPTH));
  assign imem.req  = req;
  assign imem.addr = fetch_pc_q;

  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign pc_o          = fifo_empty ? fetch_pc_q : fifo_head.pc;
  assign pc_plus4_o    = pc_o + ADDR_WIDTH'(4);
  assign misalign_o    = misalign_q;

  // Fetch FSM next state; a redirect turns any in-flight response stale
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fifo_push  = 1'b0;
    case (state_q)
      FsReq: begin
        if (req && imem.gnt) state_d = taken ? FsDrop : FsWait;
      end
      FsWait: begin
        if (imem.rvalid) begin
          state_d = FsReq;
          if (!taken) begin
            fifo_push  = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          end
        end else if (taken) begin
          state_d = FsDrop;
        end
      end
      FsDrop: begin
        if (imem.rvalid) state_d = FsReq;
      end
      default: state_d = FsReq;
    endcase
    if (taken) fetch_pc_d = {target[ADDR_WIDTH-1:2], 2'b00};
  end

  // State, PC and misalign pulse registers; fetch_en_q delays the first request by a cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FsReq;
      fetch_pc_q <= RESET_PC;
      fetch_en_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fetch_en_q <= 1'b1;
      misalign_q <= taken & target[1];
    end
  end

  instr_fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  ('{instr: imem.rdata, pc: fetch_pc_q}),
    .pop_i   (fire),
    .flush_i (taken),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A response must always find a free slot
  assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_push |-> !fifo_full);

endmodule
